// File: rtl/semiauto_pkg.sv
// Shared encodings for the semi-auto navigation path: navigation FSM states,
// global mode codes, command-latch states and the command priority helper.
package semiauto_pkg;

    typedef enum logic [1:0] {
        S_WAIT    = 2'b00,
        S_FORWARD = 2'b01,
        S_TURN    = 2'b10,
        S_COOL    = 2'b11
    } nav_state_e;

    // Modes 01 and 10 are the only ones in which the latch is live.
    typedef enum logic [1:0] {
        GM_OFF   = 2'b00,
        GM_MODE1 = 2'b01,
        GM_MODE2 = 2'b10,
        GM_MODE3 = 2'b11
    } global_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        HOLD    = 2'b10,
        RELEASE = 2'b11
    } latch_state_e;

    localparam int CMD_LEFT     = 0;
    localparam int CMD_RIGHT    = 1;
    localparam int CMD_STRAIGHT = 2;
    localparam int CMD_BACK     = 3;

    // Reduce a set of simultaneous rising edges to one command: straight > back > left > right.
    function automatic logic [3:0] pick_cmd(input logic [3:0] rise);
        logic [3:0] cmd;
        cmd = 4'b0000;
        if (rise[CMD_STRAIGHT]) begin
            cmd[CMD_STRAIGHT] = 1'b1;
        end else if (rise[CMD_BACK]) begin
            cmd[CMD_BACK] = 1'b1;
        end else if (rise[CMD_LEFT]) begin
            cmd[CMD_LEFT] = 1'b1;
        end else if (rise[CMD_RIGHT]) begin
            cmd[CMD_RIGHT] = 1'b1;
        end else begin
            cmd = 4'b0000;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/semiauto_cmd_latch_btn_debounce.sv
// Two-flop synchroniser plus saturating stability counter for one push-button.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = 21
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // Next-state for the synchroniser, counter and debounced level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/semiauto_cmd_latch.sv
// Debounces the four direction buttons and latches one command per crossroad.
// Optional HOLD timeout is enabled by defining SEMIAUTO_CMD_TIMEOUT_EN.
module semiauto_cmd_latch
    import semiauto_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = 21
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 500_000_000
`endif
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] state,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_straight,
    input  logic       btn_back,
    output logic       left,
    output logic       right,
    output logic       straight,
    output logic       back,
    output logic       cmd_pending
);

`ifdef SEMIAUTO_CMD_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    logic [TO_W-1:0]             hold_cnt_q, hold_cnt_d;
`endif

    logic [3:0]   btn_raw_s;
    logic [3:0]   db_s;
    logic [3:0]   rise_s;
    logic         active_s;
    logic [3:0]   db_prev_q, db_prev_d;
    logic [3:0]   cmd_q, cmd_d;
    logic         seen_wait_q, seen_wait_d;
    logic         pending_q, pending_d;
    latch_state_e latch_q, latch_d;

    assign btn_raw_s = {btn_back, btn_straight, btn_right, btn_left};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .sys_clk (sys_clk),
            .rst     (rst),
            .btn_raw (btn_raw_s[i]),
            .btn_db  (db_s[i])
        );
    end

    assign active_s = power && ((global_state == GM_MODE1) || (global_state == GM_MODE2));
    assign rise_s   = db_s & ~db_prev_q;

    // Latch FSM next-state; a consumed command needs a visit to S_WAIT followed by leaving it.
    always_comb begin
        db_prev_d   = db_s;
        latch_d     = latch_q;
        cmd_d       = cmd_q;
        seen_wait_d = seen_wait_q;
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        if (!active_s) begin
            latch_d     = IDLE;
            cmd_d       = 4'b0000;
            seen_wait_d = 1'b0;
        end else begin
            case (latch_q)
                IDLE: begin
                    latch_d = RELEASE;
                    cmd_d   = 4'b0000;
                end
                ARMED: begin
                    if (rise_s != 4'b0000) begin
                        latch_d     = HOLD;
                        cmd_d       = pick_cmd(rise_s);
                        seen_wait_d = 1'b0;
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
                        hold_cnt_d  = '0;
`endif
                    end else begin
                        cmd_d = 4'b0000;
                    end
                end
                HOLD: begin
                    if (seen_wait_q && (state != S_WAIT)) begin
                        latch_d = RELEASE;
                        cmd_d   = 4'b0000;
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
                    end else if (hold_cnt_q == TO_LAST) begin
                        latch_d = RELEASE;
                        cmd_d   = 4'b0000;
`endif
                    end else begin
                        seen_wait_d = seen_wait_q | (state == S_WAIT);
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
                        hold_cnt_d  = hold_cnt_q + TO_ONE;
`endif
                    end
                end
                RELEASE: begin
                    cmd_d = 4'b0000;
                    if (db_s == 4'b0000) begin
                        latch_d = ARMED;
                    end else begin
                        latch_d = RELEASE;
                    end
                end
                default: begin
                    latch_d = IDLE;
                    cmd_d   = 4'b0000;
                end
            endcase
        end
        pending_d = (latch_d == HOLD);
    end

    // Latch FSM and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            latch_q     <= IDLE;
            db_prev_q   <= 4'b0000;
            cmd_q       <= 4'b0000;
            seen_wait_q <= 1'b0;
            pending_q   <= 1'b0;
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            latch_q     <= latch_d;
            db_prev_q   <= db_prev_d;
            cmd_q       <= cmd_d;
            seen_wait_q <= seen_wait_d;
            pending_q   <= pending_d;
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign left        = cmd_q[CMD_LEFT];
    assign right       = cmd_q[CMD_RIGHT];
    assign straight    = cmd_q[CMD_STRAIGHT];
    assign back        = cmd_q[CMD_BACK];
    assign cmd_pending = pending_q;

endmodule

// File: tb/tb_semiauto_cmd_latch.sv
// Scoreboard bench for semiauto_cmd_latch: a cycle reference model pushes the expected
// outputs after each clock edge and a monitor pops and compares them on the falling edge.
module tb_semiauto_cmd_latch;

    localparam int DEB = 4;
    localparam int TO  = 16;
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_REL  = 1;
    localparam int PH_ARM  = 2;
    localparam int PH_HOLD = 3;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       power;
    logic [1:0] global_state;
    logic [1:0] state;
    logic       btn_left, btn_right, btn_straight, btn_back;
    logic       left, right, straight, back, cmd_pending;

    always #5 sys_clk = ~sys_clk;

    semiauto_cmd_latch #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
`ifdef SEMIAUTO_CMD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES  (TO)
`endif
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .power        (power),
        .global_state (global_state),
        .state        (state),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_straight (btn_straight),
        .btn_back     (btn_back),
        .left         (left),
        .right        (right),
        .straight     (straight),
        .back         (back),
        .cmd_pending  (cmd_pending)
    );

    int checks   = 0;
    int failures = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;

    // Reference model: raw history, debounced levels, run lengths, latch phase.
    logic [3:0] h1_m, h2_m, db_m, dbp_m, cmd_m;
    int         run_m [4];
    int         phase_m, held_m;
    bit         seen_m;

    function automatic logic [3:0] pick(input logic [3:0] r);
        if (r[2]) return 4'b0100;
        if (r[3]) return 4'b1000;
        if (r[0]) return 4'b0001;
        if (r[1]) return 4'b0010;
        return 4'b0000;
    endfunction

    task automatic model_edge();
        logic [3:0] raw, rise;
        bit act;
        raw = {btn_back, btn_straight, btn_right, btn_left};
        if (rst) begin
            h1_m = 4'b0; h2_m = 4'b0; db_m = 4'b0; dbp_m = 4'b0; cmd_m = 4'b0;
            for (int b = 0; b < 4; b++) run_m[b] = 0;
            phase_m = PH_IDLE; held_m = 0; seen_m = 1'b0;
        end else begin
            rise = db_m & ~dbp_m;
            act  = power && (global_state == 2'b01 || global_state == 2'b10);
            if (!act) begin
                phase_m = PH_IDLE;
                cmd_m   = 4'b0;
            end else if (phase_m == PH_IDLE) begin
                phase_m = PH_REL;
            end else if (phase_m == PH_REL) begin
                if (db_m == 4'b0) phase_m = PH_ARM;
            end else if (phase_m == PH_ARM) begin
                if (rise != 4'b0) begin
                    cmd_m = pick(rise); phase_m = PH_HOLD; held_m = 0; seen_m = 1'b0;
                end
            end else begin
                held_m++;
                if ((seen_m && state != 2'b00) || (TO_EN && held_m == TO)) begin
                    cmd_m = 4'b0; phase_m = PH_REL;
                end else if (state == 2'b00) begin
                    seen_m = 1'b1;
                end
            end
            // A level flips on the DEB-th consecutive cycle the synchronised input disagrees.
            dbp_m = db_m;
            for (int b = 0; b < 4; b++) begin
                if (h2_m[b] != db_m[b]) begin
                    run_m[b]++;
                    if (run_m[b] == DEB) begin
                        db_m[b]  = ~db_m[b];
                        run_m[b] = 0;
                    end
                end else begin
                    run_m[b] = 0;
                end
            end
            h2_m = h1_m;
            h1_m = raw;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_edge();
        exp_q.push_back({phase_m == PH_HOLD, cmd_m});
        @(negedge sys_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_btn(input logic [3:0] v);
        {btn_back, btn_straight, btn_right, btn_left} = v;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: compare every presented output sample against the scoreboard.
    always @(negedge sys_clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            checks++;
            if ({cmd_pending, back, straight, right, left} !== mon_exp) begin
                failures++;
                $display("FAIL outputs got=%b exp=%b t=%0t",
                         {cmd_pending, back, straight, right, left}, mon_exp, $time);
            end
        end
    end

    initial begin
        int  lat;
        bit  got;
        logic [3:0] rb;
        rst = 1'b1; power = 1'b1; global_state = 2'b01; state = 2'b00;
        set_btn(4'b0000);
        run(3);
        rst = 1'b0;
        run(4);

        // Settle latency: straight held, command shows 7 edges after the press.
        set_btn(4'b0100);
        lat = 0; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            if (straight) begin got = 1'b1; lat = i; end
        end
        checks++;
        if (lat != 7) begin
            failures++;
            $display("FAIL settle_latency got=%0d exp=7", lat);
        end
        run(3);
        state = 2'b01; tick();
        check_bit("consume_clears", straight, 1'b0);
        run(10);
        state = 2'b00; run(5);
        set_btn(4'b0000); run(10);

        // Priority: left+right gives left, back+left gives back.
        set_btn(4'b0011); run(8);
        check_bit("prio_left", left, 1'b1);
        check_bit("prio_right", right, 1'b0);
        set_btn(4'b0000); run(8);
        state = 2'b01; run(2); state = 2'b00; run(4);
        set_btn(4'b1001); run(8);
        check_bit("prio_back", back, 1'b1);
        set_btn(4'b0000); run(8);
        state = 2'b10; run(2); state = 2'b00; run(4);

        // Bounce rejection on btn_right.
        for (int i = 0; i < 6; i++) begin
            set_btn(4'b0010); run(2);
            set_btn(4'b0000); run(2);
        end
        run(8);

        // Early press during forward travel is kept through the crossroad.
        state = 2'b01; set_btn(4'b1000); run(8);
        set_btn(4'b0000); run(6);
        check_bit("early_back", back, 1'b1);
        state = 2'b00; run(5);
        state = 2'b10; run(3);
        state = 2'b11; run(3);
        state = 2'b00; run(4);

        // Disable via global_state, then reset in HOLD.
        set_btn(4'b0001); run(8);
        set_btn(4'b0000);
        global_state = 2'b00; tick();
        check_bit("disable_clears", left, 1'b0);
        global_state = 2'b01; run(10);
        set_btn(4'b0001); run(8);
        set_btn(4'b0000); run(2);
        rst = 1'b1; tick(); rst = 1'b0;
        check_bit("rst_clears", left, 1'b0);
        run(10);

        // Timeout: forward travel never reaches the waiting state.
        state = 2'b01; set_btn(4'b0100); run(8);
        set_btn(4'b0000); run(100);
        check_bit("timeout_hold", straight, !TO_EN);
        state = 2'b00; run(3); state = 2'b10; run(10);

        // Randomised traffic.
        rb = 4'b0000;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'(1 << $urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) rb = 4'b0000;
                set_btn(rb);
            end
            if ($urandom_range(0, 11) == 0) state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) global_state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) power = ~power;
            if ($urandom_range(0, 40) == 0) begin power = 1'b1; global_state = 2'b01; end
            rst = ($urandom_range(0, 699) == 0);
            tick();
        end
        rst = 1'b0;
        run(2);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
